// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: single-port PDP-11 memory arbiter, EX priority with IF anti-starvation.
// Optional macro PDP_ODD_ADDR_TRAP_EN adds odd_trap for odd-address accesses.
module pdp_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_gnt,
  output logic              ex_rvalid,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef PDP_ODD_ADDR_TRAP_EN
  ,
  output logic              odd_trap
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] SMAX  = 4'(STARVE_MAX);
  localparam logic [2:0] WLOAD =
    (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

  state_t state, state_nx;
  logic [2:0] wcnt, wcnt_nx;
  logic [3:0] starve, starve_nx;

  logic              own_ex;
  logic              we_q;
  logic              trap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ex_rdata_q;
  logic [DATA_W-1:0] resp_data;

  logic              arb;
  logic              take;
  logic              pick_ex;
  logic              odd_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              acc;
  logic              rsp;

  assign arb      = (state == S_IDLE) || (state == S_RESP);
  assign take     = arb && (if_req || ex_req);
  assign pick_ex  = ex_req && !(if_req && (starve == SMAX));
  assign sel_addr = pick_ex ? ex_addr : if_addr;

`ifdef PDP_ODD_ADDR_TRAP_EN
  assign odd_sel = sel_addr[0];
`else
  logic unused_bit0;
  assign odd_sel     = 1'b0;
  assign unused_bit0 = sel_addr[0];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      wcnt   <= wcnt_nx;
      starve <= starve_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    starve_nx = starve;
    unique case (state)
      S_IDLE, S_RESP: begin
        state_nx = take ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        if (trap_q || (MEM_LAT == 1)) begin
          state_nx = S_RESP;
        end else begin
          state_nx = S_WAIT;
          wcnt_nx  = WLOAD;
        end
      end
      S_WAIT: begin
        if (wcnt == '0) state_nx = S_RESP;
        else wcnt_nx = wcnt - 3'd1;
      end
    endcase
    // EX beating a waiting IF ages IF; any IF grant forgives it
    if (take) begin
      if (!pick_ex) starve_nx = '0;
      else if (if_req && (starve != SMAX)) starve_nx = starve + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      own_ex  <= 1'b0;
      we_q    <= 1'b0;
      trap_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      own_ex  <= pick_ex;
      we_q    <= pick_ex && ex_we;
      trap_q  <= odd_sel;
      addr_q  <= {sel_addr[ADDR_W-1:1], 1'b0};
      wdata_q <= pick_ex ? ex_wdata : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_q <= '0;
      ex_rdata_q <= '0;
    end else if (rsp) begin
      if (own_ex) ex_rdata_q <= resp_data;
      else if_rdata_q <= resp_data;
    end
  end

  assign acc       = (state == S_ACCESS);
  assign rsp       = (state == S_RESP);
  assign resp_data = (we_q || trap_q) ? '0 : mem_rdata;

  assign if_gnt    = acc && !own_ex;
  assign ex_gnt    = acc && own_ex;
  assign mem_en    = acc && !trap_q;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  assign if_rvalid = rsp && !own_ex;
  assign ex_rvalid = rsp && own_ex;
  assign if_rdata  = if_rvalid ? resp_data : if_rdata_q;
  assign ex_rdata  = ex_rvalid ? resp_data : ex_rdata_q;
  assign busy      = (state != S_IDLE);

`ifdef PDP_ODD_ADDR_TRAP_EN
  assign odd_trap  = rsp && trap_q;
`endif

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter: scoreboard bench for pdp_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// Responses are queued at stimulus time and compared when rvalid appears.
module tb_pdp_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        ex_req = 1'b0;
  logic        ex_we = 1'b0;
  logic [15:0] ex_addr = '0;
  logic [15:0] ex_wdata = '0;
  logic        ex_gnt, ex_rvalid;
  logic [15:0] ex_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic        odd_trap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_ex;
    logic [15:0] data;
    bit          trap;
  } exp_t;
  exp_t sb[$];

  pdp_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_gnt(ex_gnt),
    .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef PDP_ODD_ADDR_TRAP_EN
    , .odd_trap(odd_trap)
`endif
  );

`ifndef PDP_ODD_ADDR_TRAP_EN
  assign odd_trap = 1'b0;
`endif

  always #5 clock = ~clock;

  // memory model: two-cycle read pipeline
  logic [15:0] mem [0:1023];
  logic [15:0] pipe0 = '0;
  logic [15:0] pipe1 = '0;
  assign mem_rdata = pipe1;

  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr[10:1]] <= mem_wdata;
    pipe0 <= (mem_en && !mem_we) ? mem[mem_addr[10:1]] : 16'hDEAD;
    pipe1 <= pipe0;
  end

  always @(negedge clock) begin
    exp_t e;
    logic [15:0] got;
    if (reset_n && (if_rvalid || ex_rvalid)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected if_rvalid=%0b ex_rvalid=%0b",
                 if_rvalid, ex_rvalid);
      end else begin
        e = sb.pop_front();
        got = e.is_ex ? ex_rdata : if_rdata;
        if ((e.is_ex ? !ex_rvalid : !if_rvalid) ||
            (e.is_ex ? if_rvalid : ex_rvalid) ||
            got !== e.data || odd_trap !== e.trap) begin
          errors++;
          $display("FAIL sb_resp got ex=%0b if=%0b data=%h trap=%0b exp ex=%0b data=%h trap=%0b",
                   ex_rvalid, if_rvalid, got, odd_trap, e.is_ex, e.data, e.trap);
        end
      end
    end
  end

  task automatic do_req(input bit is_ex, input bit we,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat);
    lat = -1;
    if (is_ex) begin
      ex_req = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (is_ex ? ex_gnt : if_gnt) begin
        lat = k;
        break;
      end
    end
    if (is_ex) ex_req = 1'b0;
    else if_req = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL gnt_timeout ex=%0b addr=%h", is_ex, addr);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, ex_gnt, ex_rvalid, ex_rdata,
         mem_en, mem_we, mem_addr, mem_wdata, busy, odd_trap} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero busy=%0b mem_en=%0b", busy, mem_en);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_if_read();
    int lat;
    sb.push_back('{is_ex: 1'b0, data: 16'h1234, trap: 1'b0});
    do_req(1'b0, 1'b0, 16'h0010, 16'h0, lat);
    checks++;
    if (lat !== 1 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
        mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL if_read_access lat=%0d en=%0b we=%0b addr=%h exp 1 1 0 0010",
               lat, mem_en, mem_we, mem_addr);
    end
    @(negedge clock);
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL if_read_wait rvalid=%0b busy=%0b exp 0 1", if_rvalid, busy);
    end
    @(negedge clock);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234 || ex_rdata !== 16'h0) begin
      errors++;
      $display("FAIL if_read_resp rvalid=%0b rdata=%h ex_rdata=%h exp 1 1234 0000",
               if_rvalid, if_rdata, ex_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_ex_write();
    int lat;
    int rv_at = -1;
    bit if_seen = 1'b0;
    logic [15:0] rd = 16'hFFFF;
    sb.push_back('{is_ex: 1'b1, data: 16'h0000, trap: 1'b0});
    do_req(1'b1, 1'b1, 16'h0200, 16'hBEEF, lat);
    checks++;
    if (lat !== 1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_wdata !== 16'hBEEF || mem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL ex_write_access lat=%0d en=%0b we=%0b wdata=%h addr=%h",
               lat, mem_en, mem_we, mem_wdata, mem_addr);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (ex_rvalid && rv_at < 0) begin
        rv_at = k;
        rd = ex_rdata;
      end
      if (if_rvalid) if_seen = 1'b1;
    end
    checks++;
    if (rv_at !== 2 || rd !== 16'h0 || if_seen) begin
      errors++;
      $display("FAIL ex_write_resp at=%0d rdata=%h if_rvalid_seen=%0b exp 2 0000 0",
               rv_at, rd, if_seen);
    end
    checks++;
    if (if_rdata !== 16'h1234 || mem[16'h0200 >> 1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL ex_write_hold if_rdata=%h mem=%h exp 1234 beef",
               if_rdata, mem[16'h0200 >> 1]);
    end
  endtask

  task automatic test_starvation();
    bit order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    int last = 0;
    for (int i = 0; i < 6; i++)
      sb.push_back(order[i] ? '{is_ex: 1'b1, data: 16'h5A5A, trap: 1'b0}
                            : '{is_ex: 1'b0, data: 16'h7777, trap: 1'b0});
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h0300;
    if_req = 1'b1; if_addr = 16'h0040;
    for (int cyc = 1; cyc <= 40 && n < 6; cyc++) begin
      @(negedge clock);
      if (if_gnt || ex_gnt) begin
        checks++;
        if ((if_gnt && ex_gnt) || ex_gnt !== order[n]) begin
          errors++;
          $display("FAIL starve_order grant%0d ex_gnt=%0b if_gnt=%0b exp ex=%0b",
                   n, ex_gnt, if_gnt, order[n]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last !== 3) begin
            errors++;
            $display("FAIL starve_spacing grant%0d gap=%0d exp 3", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n == 6) begin
          ex_req = 1'b0;
          if_req = 1'b0;
        end
      end
    end
    ex_req = 1'b0;
    if_req = 1'b0;
    if (n < 6) begin
      checks++; errors++;
      $display("FAIL starve_timeout grants=%0d exp 6", n);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray = 0;
    do_req(1'b1, 1'b0, 16'h0300, 16'h0, lat);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %0b exp 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, ex_gnt, ex_rvalid, ex_rdata,
         mem_en, mem_we, mem_addr, mem_wdata, busy, odd_trap} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs busy=%0b if_rdata=%h ex_rdata=%h exp 0",
               busy, if_rdata, ex_rdata);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (if_rvalid || ex_rvalid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL mid_stray_rvalid count=%0d exp 0", stray);
    end
    sb.push_back('{is_ex: 1'b0, data: 16'h0BAD, trap: 1'b0});
    do_req(1'b0, 1'b0, 16'h0080, 16'h0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL mid_regrant_latency got %0d exp 1", lat);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap = -1;
    int idle_seen = 0;
    sb.push_back('{is_ex: 1'b1, data: 16'h5A5A, trap: 1'b0});
    do_req(1'b1, 1'b0, 16'h0300, 16'h0, lat);
    @(negedge clock);
    @(negedge clock);
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h0082;
    if_req = 1'b1; if_addr = 16'h0040;
    sb.push_back('{is_ex: 1'b1, data: 16'hC0DE, trap: 1'b0});
    sb.push_back('{is_ex: 1'b0, data: 16'h7777, trap: 1'b0});
    @(negedge clock);
    checks++;
    if (ex_gnt !== 1'b1 || mem_en !== 1'b1 ||
        mem_addr !== 16'h0082 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_access ex_gnt=%0b en=%0b addr=%h busy=%0b exp 1 1 0082 1",
               ex_gnt, mem_en, mem_addr, busy);
    end
    ex_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (!busy) idle_seen++;
      if (if_gnt) begin
        gap = k;
        break;
      end
    end
    if_req = 1'b0;
    checks++;
    if (gap !== 3 || idle_seen !== 0) begin
      errors++;
      $display("FAIL b2b_if_follow gap=%0d idle=%0d exp 3 0", gap, idle_seen);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_odd_addr();
    int lat;
`ifdef PDP_ODD_ADDR_TRAP_EN
    sb.push_back('{is_ex: 1'b0, data: 16'h0000, trap: 1'b1});
    do_req(1'b0, 1'b0, 16'h0011, 16'h0, lat);
    checks++;
    if (lat !== 1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL odd_trap_access lat=%0d en=%0b exp 1 0", lat, mem_en);
    end
    @(negedge clock);
    checks++;
    if (if_rvalid !== 1'b1 || odd_trap !== 1'b1 || if_rdata !== 16'h0) begin
      errors++;
      $display("FAIL odd_trap_resp rvalid=%0b trap=%0b rdata=%h exp 1 1 0000",
               if_rvalid, odd_trap, if_rdata);
    end
`else
    sb.push_back('{is_ex: 1'b0, data: 16'h1234, trap: 1'b0});
    do_req(1'b0, 1'b0, 16'h0011, 16'h0, lat);
    checks++;
    if (lat !== 1 || mem_en !== 1'b1 || mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL odd_addr_clear lat=%0d en=%0b addr=%h exp 1 1 0010",
               lat, mem_en, mem_addr);
    end
`endif
    repeat (4) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[16'h0010 >> 1] = 16'h1234;
    mem[16'h0040 >> 1] = 16'h7777;
    mem[16'h0080 >> 1] = 16'h0BAD;
    mem[16'h0082 >> 1] = 16'hC0DE;
    mem[16'h0300 >> 1] = 16'h5A5A;
    test_reset();
    test_if_read();
    test_ex_write();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    test_odd_addr();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
